// File: rtl/tinyqv_serial_alu.sv
// rtl/tinyqv_serial_alu.sv - self-sequencing digit-serial ALU, DW bits per cycle, LSD first
module tinyqv_serial_alu #(
  parameter int XLEN = 32,
  parameter int DW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            cmp
);

  localparam int N  = XLEN / DW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] DMASK = XLEN'({DW{1'b1}});

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_CZEQ = 4'b1110;
  localparam logic [3:0] OP_CZNE = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [CW-1:0]   cnt;
  logic            carry, eq, bz;

  int              base;
  logic [DW-1:0]   a_d, b_d, bx_d, dig;
  logic [DW:0]     sum;
  logic [XLEN-1:0] shifted;
  logic [SW-1:0]   shamt;
  logic            subtract, eq_n, bz_n, cmp_fin, last;

  always_comb begin
    base     = int'(cnt) * DW;
    a_d      = DW'(a_q >> base);
    b_d      = DW'(b_q >> base);
    subtract = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU);
    bx_d     = subtract ? ~b_d : b_d;
    sum      = {1'b0, a_d} + {1'b0, bx_d} + {{DW{1'b0}}, carry};
    // Shifts see the full latched operand; only the current digit is taken each cycle.
    shamt    = b_q[SW-1:0];
    shifted  = a_q >> shamt;
    if (op_q == OP_SLL) shifted = a_q << shamt;
    if (op_q == OP_SRA) shifted = $signed(a_q) >>> shamt;
    case (op_q)
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU: dig = sum[DW-1:0];
      OP_AND:                          dig = a_d & b_d;
      OP_OR:                           dig = a_d | b_d;
      OP_XOR:                          dig = a_d ^ b_d;
      OP_SLL, OP_SRL, OP_SRA:          dig = DW'(shifted >> base);
      OP_CZEQ, OP_CZNE:                dig = a_d;
      default:                         dig = '0;
    endcase
    eq_n = eq & (a_d == b_d);
    bz_n = bz & (b_d == '0);
    case (op_q)
      OP_SLTU: cmp_fin = ~sum[DW];
      OP_SLT:  cmp_fin = a_q[XLEN-1] ^ ~b_q[XLEN-1] ^ sum[DW];
      OP_XOR:  cmp_fin = eq_n;
      default: cmp_fin = 1'b0;
    endcase
    last = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      cmp    <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      eq     <= 1'b1;
      bz     <= 1'b1;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      case (state)
        RUN: begin
          result <= (result & ~(DMASK << base)) | (XLEN'(dig) << base);
          carry  <= sum[DW];
          eq     <= eq_n;
          bz     <= bz_n;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            ready <= 1'b1;
            done  <= 1'b1;
            cmp   <= cmp_fin;
            if (op_q == OP_SLT || op_q == OP_SLTU)
              result <= {{(XLEN-1){1'b0}}, cmp_fin};
            else if (op_q == OP_CZEQ)
              result <= bz_n ? '0 : a_q;
            else if (op_q == OP_CZNE)
              result <= bz_n ? a_q : '0;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            cnt   <= '0;
            carry <= (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
            eq    <= 1'b1;
            bz    <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
